// File: rtl/mcu_if.sv
// Instruction handshake, memory acknowledge and datapath control bundle
// for multicycle_control_unit; slave = control unit, master = surrounding datapath.
interface mcu_if #(
    parameter int OPCODE_WIDTH = 3,
    parameter int ALU_OP_WIDTH = 4,
    parameter int CNT_WIDTH    = 16
);
    logic                    instr_valid;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    instr_ready;
    logic                    mem_ack;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic                    alu_src;
    logic                    mem_read;
    logic                    mem_write;
    logic                    mem_to_reg;
    logic                    reg_write;
    logic                    branch;
    logic                    busy;
    logic                    illegal_op;
    logic                    mem_timeout;
    logic [CNT_WIDTH-1:0]    retired_count;

    modport slave (
        input  instr_valid, opcode, mem_ack,
        output instr_ready, alu_op, alu_src, mem_read, mem_write, mem_to_reg,
               reg_write, branch, busy, illegal_op, mem_timeout, retired_count
    );

    modport master (
        output instr_valid, opcode, mem_ack,
        input  instr_ready, alu_op, alu_src, mem_read, mem_write, mem_to_reg,
               reg_write, branch, busy, illegal_op, mem_timeout, retired_count
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle IDLE/DECODE/EXEC/MEM/WB control unit with a bounded memory wait.
// Define MCU_RETIRE_COUNT_EN to build the retired-instruction counter.
module multicycle_control_unit #(
    parameter int OPCODE_WIDTH = 3,
    parameter int ALU_OP_WIDTH = 4,
    parameter int MEM_TIMEOUT  = 15,
    parameter int CNT_WIDTH    = 16
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    mcu_if.slave  bus
);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

    state_t                  r_state, w_next;
    logic [OPCODE_WIDTH-1:0] r_opcode;
    logic [TW-1:0]           r_cnt;
    logic                    r_mem_timeout;
    logic                    w_timeout;
    logic [2:0]              w_op3;
    logic                    w_illegal, w_is_sw, w_is_lw, w_is_beq, w_is_mem, w_limit;
    logic [3:0]              w_alu4;

    assign w_op3     = r_opcode[2:0];
    assign w_illegal = (r_opcode >> 3) != '0;
    assign w_is_sw   = !w_illegal && (w_op3 == 3'd3);
    assign w_is_lw   = !w_illegal && (w_op3 == 3'd4);
    assign w_is_beq  = !w_illegal && (w_op3 == 3'd5);
    assign w_is_mem  = w_is_sw || w_is_lw;
    assign w_limit   = (r_cnt == TW'(MEM_TIMEOUT - 1));

    always_comb begin
        case (w_op3)
            3'd0, 3'd3, 3'd4: w_alu4 = 4'b0010;
            3'd1, 3'd5:       w_alu4 = 4'b0110;
            3'd2:             w_alu4 = 4'b0111;
            3'd6:             w_alu4 = 4'b0000;
            default:          w_alu4 = 4'b0001;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_opcode      <= '0;
            r_cnt         <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_mem_timeout <= w_timeout;
            if (r_state == S_IDLE && bus.instr_valid)
                r_opcode <= bus.opcode;
            // Counter only lives while the FSM stays in MEM, so any exit clears it.
            r_cnt <= (r_state == S_MEM && w_next == S_MEM) ? r_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_timeout      = 1'b0;
        bus.instr_ready = 1'b0;
        bus.alu_op     = '0;
        bus.alu_src    = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.branch     = 1'b0;
        bus.illegal_op = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) w_next = S_DECODE;
            end
            S_DECODE: begin
                bus.illegal_op = w_illegal;
                w_next = w_illegal ? S_IDLE : S_EXEC;
            end
            S_EXEC: begin
                bus.alu_op  = ALU_OP_WIDTH'(w_alu4);
                bus.alu_src = w_is_mem;
                bus.branch  = w_is_beq;
                if (w_is_beq)      w_next = S_IDLE;
                else if (w_is_mem) w_next = S_MEM;
                else               w_next = S_WB;
            end
            S_MEM: begin
                bus.alu_op    = ALU_OP_WIDTH'(w_alu4);
                bus.alu_src   = 1'b1;
                bus.mem_write = w_is_sw;
                bus.mem_read  = w_is_lw;
                // An ack on the limit cycle takes priority over the timeout.
                if (bus.mem_ack) begin
                    w_next = w_is_sw ? S_IDLE : S_WB;
                end else if (w_limit) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = w_is_lw;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.mem_timeout = r_mem_timeout;

`ifdef MCU_RETIRE_COUNT_EN
    logic                 w_retire;
    logic [CNT_WIDTH-1:0] r_retired;

    assign w_retire = (r_state == S_EXEC && w_is_beq) ||
                      (r_state == S_MEM && w_is_sw && bus.mem_ack) ||
                      (r_state == S_WB);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      r_retired <= '0;
        else if (w_retire) r_retired <= r_retired + 1'b1;
    end

    assign bus.retired_count = r_retired;
`else
    assign bus.retired_count = {CNT_WIDTH{1'b0}};
`endif
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised, sequential successor to the single-cycle opcode decoder.
- Accepts one instruction opcode per valid/ready handshake and steps it through a DECODE/EXEC/MEM/WB state machine.
- Drives per-phase datapath control strobes, and waits on a memory acknowledge with a timeout.
- Sits between the instruction register and the ALU/register-file/data-memory datapath.

Parameters:
- OPCODE_WIDTH, 3, opcode input width; must be >= 3.
- ALU_OP_WIDTH, 4, width of the alu_op output.
- MEM_TIMEOUT, 15, maximum cycles spent in MEM waiting for mem_ack; must be >= 1.
- CNT_WIDTH, 16, width of retired_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  opcode is valid this cycle.
- opcode  input  OPCODE_WIDTH  instruction opcode.
- instr_ready  output  1  unit is idle and can accept an opcode.
- mem_ack  input  1  data memory has completed the current access.
- alu_op  output  ALU_OP_WIDTH  ALU operation select.
- alu_src  output  1  1 = immediate operand, 0 = register operand.
- mem_read  output  1  data memory read strobe.
- mem_write  output  1  data memory write strobe.
- mem_to_reg  output  1  write-back source is memory.
- reg_write  output  1  register file write enable.
- branch  output  1  branch-compare strobe.
- busy  output  1  state is not IDLE.
- illegal_op  output  1  one-cycle pulse when an opcode is unknown.
- mem_timeout  output  1  one-cycle pulse when the MEM wait is aborted.
- retired_count  output  CNT_WIDTH  count of retired instructions (see Optional Feature).

Behaviour:
- Reset: all of the following clear to 0 asynchronously: state (goes to IDLE), opcode_q, timeout counter, and every output, except instr_ready = 1.
- Output timing: outputs decode only from the registered state, opcode_q and the timeout counter. There is no combinational path from any input to any output.
- Opcode table (opcode_q -> alu_op, class):
  - 0 ADD -> 0010, R
  - 1 SUB -> 0110, R
  - 2 SLT -> 0111, R
  - 3 SW -> 0010, store
  - 4 LW -> 0010, load
  - 5 BEQ -> 0110, branch
  - 6 AND -> 0000, R
  - 7 OR -> 0001, R
  - Values >= 8 are illegal; this only applies when OPCODE_WIDTH > 3.
  - alu_op values are zero-extended or truncated to ALU_OP_WIDTH.
- IDLE:
  - instr_ready = 1.
  - On instr_valid: capture opcode into opcode_q and go to DECODE.
  - With instr_valid low, stay in IDLE.
- DECODE:
  - Illegal opcode: illegal_op = 1 for this cycle, then go to IDLE.
  - Otherwise go to EXEC.
- EXEC:
  - Drive alu_op.
  - alu_src = 1 for SW and LW.
  - BEQ: branch = 1 for this cycle, then go to IDLE; the instruction retires.
  - R-class goes to WB; SW and LW go to MEM.
- MEM:
  - SW holds mem_write = 1; LW holds mem_read = 1; alu_op and alu_src are held.
  - The timeout counter increments each cycle spent in MEM.
  - mem_ack = 1: SW goes to IDLE (retires); LW goes to WB.
  - Timeout: if the counter reaches MEM_TIMEOUT without mem_ack, mem_timeout = 1 for one cycle, strobes drop, and the state goes to IDLE with no retire. The counter is cleared on MEM exit.
  - mem_ack arriving on the same cycle as the timeout limit: the ack wins.
  - mem_ack outside MEM is ignored.
- WB:
  - reg_write = 1 for exactly one cycle; mem_to_reg = 1 for LW only.
  - Next state is IDLE; the instruction retires.
- Latency, counted from the accepting edge (cycle 0):
  - R-class: reg_write in cycle 3, back in IDLE at cycle 4.
  - BEQ: branch in cycle 2.
  - SW and LW with immediate ack: MEM in cycle 3; LW reg_write in cycle 4.
- Handshake:
  - No new opcode is accepted while busy; instr_valid is ignored.
  - Back-to-back acceptance is allowed on the first IDLE cycle.
- Reset mid-operation aborts immediately: no strobe survives, the instruction does not retire, and retired_count clears.

Optional Feature:
- Macro: MCU_RETIRE_COUNT_EN.
- Defined: retired_count increments by 1 on each retire event (BEQ EXEC exit, SW MEM ack, WB exit) and wraps from all-ones to 0. Illegal and timed-out instructions do not count.
- Undefined: the counter logic is absent and retired_count is tied to 0.

Test Plan:
- Reset with rst_n = 0 mid-MEM -> all strobes 0, instr_ready = 1, busy = 0, retired_count = 0 on the asynchronous edge.
- ADD (opcode 0) accepted at cycle 0 -> alu_op = 0010 in cycle 2, reg_write = 1 only in cycle 3, instr_ready = 1 in cycle 4.
- LW (opcode 4) with mem_ack delayed 3 cycles -> mem_read held 4 cycles, then reg_write = 1 with mem_to_reg = 1 for one cycle.
- SW (opcode 3) with no mem_ack, MEM_TIMEOUT = 15 -> mem_write held 15 cycles, mem_timeout pulses once, no reg_write, retired_count unchanged.
- OPCODE_WIDTH = 4, opcode 9 -> illegal_op pulses in cycle 1, back in IDLE in cycle 2; instr_valid held high during busy is not re-accepted.
- MCU_RETIRE_COUNT_EN defined, CNT_WIDTH = 4, 17 BEQ instructions -> branch pulses 17 times, retired_count = 1 after wrap.
